des_key_schedule: RTL and testbench

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

---
 rtl/des_key_schedule.sv | 145 ++++++++++++++
 tb/tb_des_key_schedule.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// DES round-key generator: streams K1..K16 from a PC-1-permuted key with valid/ready handshakes.
// Define DES_KEY_SCHEDULE_DECRYPT_EN to add a decrypt input that streams K16..K1 instead.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic [55:0] key_in,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round,
  output logic        done
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
  ,
  input  logic        decrypt
`endif
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // PC-2 selection, 1-based positions into the 56-bit CD register
  localparam int unsigned Pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_e      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  round_q, round_d;
  logic        done_q, done_d;
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
  logic        decrypt_q, decrypt_d;
`endif

  // Shift amount for table index 0..15 (DES rounds 1..16); returns 1 when the shift is 2
  function automatic logic shift_is_two(input logic [3:0] idx);
    return !(idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15);
  endfunction

  // new c[k] = c[(k+n) mod 28], halves rotated independently
  function automatic logic [55:0] rotl(input logic [55:0] v, input logic by2);
    logic [27:0] c, d;
    c = v[27:0];
    d = v[55:28];
    if (by2) begin
      c = {c[1:0], c[27:2]};
      d = {d[1:0], d[27:2]};
    end else begin
      c = {c[0], c[27:1]};
      d = {d[0], d[27:1]};
    end
    return {d, c};
  endfunction

`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
  function automatic logic [55:0] rotr(input logic [55:0] v, input logic by2);
    logic [27:0] c, d;
    c = v[27:0];
    d = v[55:28];
    if (by2) begin
      c = {c[25:0], c[27:26]};
      d = {d[25:0], d[27:26]};
    end else begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    return {d, c};
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    cd_d      = cd_q;
    round_d   = round_q;
    done_d    = 1'b0;
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
    decrypt_d = decrypt_q;
`endif
    case (state_q)
      StIdle: begin
        if (key_valid) begin
          state_d = StRun;
          round_d = 4'd0;
          cd_d    = rotl(key_in, 1'b0);
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
          decrypt_d = decrypt;
          // C0D0 equals C16D16, so decryption starts from the unrotated key
          if (decrypt) cd_d = key_in;
`endif
        end
      end
      StRun: begin
        if (subkey_ready) begin
          if (round_q == 4'd15) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            round_d = round_q + 4'd1;
            cd_d    = rotl(cd_q, shift_is_two(round_q + 4'd1));
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
            if (decrypt_q) cd_d = rotr(cd_q, shift_is_two(4'd15 - round_q));
`endif
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cd_q      <= '0;
      round_q   <= 4'd0;
      done_q    <= 1'b0;
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
      decrypt_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cd_q      <= cd_d;
      round_q   <= round_d;
      done_q    <= done_d;
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
      decrypt_q <= decrypt_d;
`endif
    end
  end

  always_comb begin
    subkey = '0;
    for (int i = 0; i < 48; i++) begin
      subkey[i] = cd_q[Pc2[i] - 1];
    end
  end

  assign key_ready    = (state_q == StIdle);
  assign subkey_valid = (state_q == StRun);
  assign round        = round_q;
  assign done         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the FIPS 46-3 worked-example key.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic [55:0] key_in;
  logic        key_valid;
  logic        key_ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round;
  logic        done;
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
  logic        decrypt;
`endif

  int total  = 0;
  int passed = 0;

  logic [47:0] kfips [16];
  logic [55:0] fips_key;

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round        (round),
    .done         (done)
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
    ,
    .decrypt      (decrypt)
`endif
  );

  function automatic logic [47:0] rev48(input logic [47:0] x);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[i] = x[47-i];
    return r;
  endfunction

  function automatic logic [27:0] rev28(input logic [27:0] x);
    logic [27:0] r;
    for (int i = 0; i < 28; i++) r[i] = x[27-i];
    return r;
  endfunction

  // mode 0: FIPS encrypt, 1: zero key, 2: ones key, 3: FIPS decrypt order
  function automatic logic [47:0] exp_sub(input int mode, input int r);
    case (mode)
      0:       return kfips[r];
      1:       return 48'h0;
      2:       return 48'hFFFF_FFFF_FFFF;
      default: return kfips[15-r];
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Starts at the negedge where the first subkey is shown; ends in the done cycle
  task automatic stream(input int mode, input string tag);
    for (int r = 0; r < 16; r++) begin
      check($sformatf("%s valid r%0d", tag, r), 64'(subkey_valid), 64'd1);
      check($sformatf("%s round r%0d", tag, r), 64'(round), 64'(r));
      check($sformatf("%s subkey r%0d", tag, r), 64'(rev48(subkey)), 64'(exp_sub(mode, r)));
      check($sformatf("%s no early done r%0d", tag, r), 64'(done), 64'd0);
      @(negedge clk);
    end
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " key_ready at done"}, 64'(key_ready), 64'd1);
    check({tag, " valid low at done"}, 64'(subkey_valid), 64'd0);
    check({tag, " round holds 15"}, 64'(round), 64'd15);
  endtask

  initial begin
    int cnt, cyc;
    logic seen_done;

    kfips[0]  = 48'h1B02EFFC7072; kfips[1]  = 48'h79AED9DBC9E5;
    kfips[2]  = 48'h55FC8A42CF99; kfips[3]  = 48'h72ADD6DB351D;
    kfips[4]  = 48'h7CEC07EB53A8; kfips[5]  = 48'h63A53E507B2F;
    kfips[6]  = 48'hEC84B7F618BC; kfips[7]  = 48'hF78A3AC13BFB;
    kfips[8]  = 48'hE0DBEBEDE781; kfips[9]  = 48'hB1F347BA464F;
    kfips[10] = 48'h215FD3DED386; kfips[11] = 48'h7571F59467E9;
    kfips[12] = 48'h97C5D1FABA41; kfips[13] = 48'h5F43B7F2E73A;
    kfips[14] = 48'hBF918D3D3F0A; kfips[15] = 48'hCB3D8B0E17F5;
    // literals are written bit 1 first, so reverse into index order
    fips_key = {rev28(28'b0101010101100110011110001111), rev28(28'b1111000011001100101010101111)};

    rst = 1'b1; key_valid = 1'b0; key_in = '0; subkey_ready = 1'b0;
`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
    decrypt = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset key_ready", 64'(key_ready), 64'd1);
    check("reset subkey_valid", 64'(subkey_valid), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset round", 64'(round), 64'd0);
    check("reset cd", 64'(subkey), 64'd0);
    rst = 1'b0;

    // Full-speed FIPS schedule
    key_in = fips_key; key_valid = 1'b1; subkey_ready = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    stream(0, "fips");
    @(negedge clk);
    check("done one cycle", 64'(done), 64'd0);

    // Stalls with ready pattern 1,0,0,1
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    cnt = 0; cyc = 0; seen_done = 1'b0;
    while (!seen_done && cyc < 100) begin
      subkey_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (subkey_valid) begin
        check($sformatf("stall subkey c%0d", cyc), 64'(rev48(subkey)), 64'(kfips[cnt % 16]));
        check($sformatf("stall round c%0d", cyc), 64'(round), 64'(cnt));
        if (subkey_ready) cnt++;
      end else if (done) begin
        seen_done = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    check("stall accepted count", 64'(cnt), 64'd16);
    check("stall done seen", 64'(seen_done), 64'd1);

    // Reset mid-run at round 7
    subkey_ready = 1'b1; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("abort at round 7", 64'(round), 64'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort valid", 64'(subkey_valid), 64'd0);
    check("abort key_ready", 64'(key_ready), 64'd1);
    check("abort round", 64'(round), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen_done = seen_done | done;
      @(negedge clk);
    end
    check("abort no done", 64'(seen_done), 64'd0);

    // Reset beats a simultaneous key_valid
    rst = 1'b1; key_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst priority valid", 64'(subkey_valid), 64'd0);
    @(negedge clk);
    key_valid = 1'b0;
    stream(0, "restart");

    // Back-to-back keys; key_in changes during RUN must be ignored
    key_in = fips_key; key_valid = 1'b1;
    @(negedge clk);
    key_in = '0;
    stream(0, "b2b fips");
    @(negedge clk);
    key_in = '1;
    stream(1, "zeros");
    @(negedge clk);
    key_valid = 1'b0;
    stream(2, "ones");

`ifdef DES_KEY_SCHEDULE_DECRYPT_EN
    @(negedge clk);
    key_in = fips_key; key_valid = 1'b1; decrypt = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; decrypt = 1'b0;
    stream(3, "decrypt");
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
